// File: rtl/mult_share_arbiter.sv
// Two-port arbiter in front of one shared add-shift fraction multiplier.
// Each port offers a job on a valid/ready request channel and gets the
// product back on a valid/ready response channel. Ports are granted
// round-robin, the multiplier's St/Done handshake is sequenced here, and a
// watchdog turns a job whose Done never arrives into an error response.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; grant decided combinationally
// START | one-cycle mul_St pulse; Done ignored (may be stale from last job)
// BUSY  | waiting for mul_Done; watchdog counting
// RESP  | response held on the granted port until its rsp_ready
//
// TIMEOUT must lie in 2..255 (the watchdog is 8 bits wide).
module mult_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int PWIDTH  = 2*WIDTH-1,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Rst_n,
  input  logic              req0_valid,
  input  logic [WIDTH-1:0]  req0_mplier,
  input  logic [WIDTH-1:0]  req0_mcand,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [PWIDTH-1:0] rsp0_product,
  output logic              rsp0_err,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [WIDTH-1:0]  req1_mplier,
  input  logic [WIDTH-1:0]  req1_mcand,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [PWIDTH-1:0] rsp1_product,
  output logic              rsp1_err,
  input  logic              rsp1_ready,
  output logic              mul_St,
  output logic [WIDTH-1:0]  mul_Mplier,
  output logic [WIDTH-1:0]  mul_Mcand,
  input  logic [PWIDTH-1:0] mul_Product,
  input  logic              mul_Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic [7:0]        wdog_q, wdog_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [PWIDTH-1:0] prod_q, prod_d;
  logic              err_q, err_d;
  logic              st_q, st_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;

  logic              gnt_c;
  logic              idle_c;
  logic              hs_c;
  logic              rsp_ack_c;

  // Request grant: on contention the rr pointer picks, otherwise the lone requester wins.
  always_comb begin
    gnt_c = (req0_valid && req1_valid) ? rr_q : req1_valid;
  end

  // Ready is offered only in IDLE, only to the granted port, and is forced low while in reset.
  always_comb begin
    idle_c     = (state_q == IDLE) && Rst_n;
    req0_ready = idle_c && req0_valid && !gnt_c;
    req1_ready = idle_c && req1_valid && gnt_c;
    hs_c       = req0_ready || req1_ready;
    rsp_ack_c  = gnt_q ? rsp1_ready : rsp0_ready;
  end

  // Next-state and datapath register updates for the job sequence.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    wdog_d   = wdog_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (hs_c) begin
          gnt_d    = gnt_c;
          mplier_d = gnt_c ? req1_mplier : req0_mplier;
          mcand_d  = gnt_c ? req1_mcand  : req0_mcand;
          state_d  = START;
        end
      end
      START: begin
        // mul_Done is not looked at here: it can still be high from the previous job.
        wdog_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wdog_d = wdog_q + 8'd1;
        if (mul_Done) begin
          prod_d  = mul_Product;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wdog_q == WDOG_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ack_c) begin
          rr_d    = ~gnt_q;
          state_d = IDLE;
        end
      end
    endcase
    st_d         = (state_d == START);
    rsp0_valid_d = (state_d == RESP) && !gnt_d;
    rsp1_valid_d = (state_d == RESP) && gnt_d;
  end

  // All state, including the registered handshake outputs, with async reset.
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      gnt_q        <= 1'b0;
      wdog_q       <= '0;
      mplier_q     <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
      st_q         <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      wdog_q       <= wdog_d;
      mplier_q     <= mplier_d;
      mcand_q      <= mcand_d;
      prod_q       <= prod_d;
      err_q        <= err_d;
      st_q         <= st_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // Output mapping; result fields read as zero on the port that is not being answered.
  always_comb begin
    mul_St       = st_q;
    mul_Mplier   = mplier_q;
    mul_Mcand    = mcand_q;
    rsp0_valid   = rsp0_valid_q;
    rsp1_valid   = rsp1_valid_q;
    rsp0_product = rsp0_valid_q ? prod_q : '0;
    rsp1_product = rsp1_valid_q ? prod_q : '0;
    rsp0_err     = rsp0_valid_q && err_q;
    rsp1_err     = rsp1_valid_q && err_q;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one fraction_multiplier4 instance between two requesters (port 0, port 1).
- Per requester: valid/ready request channel carrying operands, valid/ready response channel returning the product.
- Round-robin arbitration; sequences the multiplier's St/Done protocol; a watchdog aborts a job whose Done never arrives.
- Sits between the client datapaths and the shared add-shift multiplier.

Parameters:
- WIDTH, 4, operand width; matches the multiplier's Mplier/Mcand width.
- PWIDTH, 2*WIDTH-1, product width; matches the multiplier's Product width.
- TIMEOUT, 15, maximum BUSY cycles to wait for mul_Done before aborting; range 2..255.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 has a job.
- req0_mplier  in  WIDTH  port 0 multiplier operand (signed fraction).
- req0_mcand  in  WIDTH  port 0 multiplicand operand (signed fraction).
- req0_ready  out  1  port 0 job accepted this cycle.
- rsp0_valid  out  1  port 0 result available.
- rsp0_product  out  PWIDTH  port 0 result.
- rsp0_err  out  1  port 0 result aborted by timeout.
- rsp0_ready  in  1  port 0 consumes the result.
- req1_valid, req1_mplier, req1_mcand, req1_ready, rsp1_valid, rsp1_product, rsp1_err, rsp1_ready: same as port 0, for port 1.
- mul_St  out  1  start pulse to the multiplier.
- mul_Mplier  out  WIDTH  operand to the multiplier.
- mul_Mcand  out  WIDTH  operand to the multiplier.
- mul_Product  in  PWIDTH  multiplier result.
- mul_Done  in  1  multiplier completion flag.

Behaviour:
- Reset (async, Rst_n=0) sets all of the following:
  - state=IDLE, rr pointer=0, grant register=0, watchdog count=0.
  - Operand registers=0, product/err registers=0.
  - Outputs: mul_St=0, all reqN_ready=0, all rspN_valid=0, rspN_err=0, rspN_product=0.
- Reset mid-job drops the job; no response is issued for it.
- States: IDLE, START, BUSY, RESP.
- IDLE:
  - Grant (combinational): if both ports are valid, grant the port equal to the rr pointer; if one port is valid, grant that port.
  - reqN_ready=1 only for the granted port, only in IDLE. ready never asserts without the matching valid.
  - On handshake: latch the operands and the grant, then go to START.
- START (exactly 1 cycle):
  - mul_St=1; mul_Mplier/mul_Mcand driven from the latched operands.
  - mul_Done is ignored in this cycle, because the multiplier may still flag the previous job.
  - Clear the watchdog, then go to BUSY.
- BUSY:
  - mul_St=0; operands held stable; watchdog increments every cycle.
  - On the first cycle with mul_Done=1: capture mul_Product, set err=0, go to RESP.
  - Else, if watchdog==TIMEOUT-1: set product=0, err=1, go to RESP.
  - If mul_Done arrives in the same cycle as the timeout, Done wins.
- RESP:
  - rspG_valid=1 for the granted port G; rspG_product/rspG_err come from registers and are stable while valid.
  - No new request is accepted in RESP.
  - On rspG_ready=1: rr pointer := ~G, go to IDLE. The next acceptance is at least 1 cycle later.
  - The other port's rsp_valid stays 0 throughout.
- Latency: request handshake to rsp_valid = 2 + D cycles, where D is the number of cycles after START until mul_Done.
- mul_Mplier/mul_Mcand hold the last operands outside a job; only mul_St indicates a new job.
- Backpressure: a held response (rsp_ready=0) blocks both ports indefinitely; the watchdog does not run in RESP.
- A port whose valid drops in IDLE before its ready is simply not served; no state change.

Test Plan:
- Single job, port 0: mplier=4'b0100, mcand=4'b0100. Behavioural multiplier model gives Done 5 cycles after St. Required: req0_ready one cycle, mul_St one cycle, rsp0_valid after 7 cycles, rsp0_product=7'h10, rsp0_err=0.
- Both ports valid in the same cycle after reset: port 0 served first. Then port 1 (mplier=4'b1100, mcand=4'b0100) gives rsp1_product=7'h70. Then port 0 again gets priority only after port 1 is served.
- Port 0 requests back-to-back continuously while port 1 is valid once: port 1 is granted on the next IDLE after the current port-0 job; alternation is strict.
- Model never asserts Done: rsp_valid exactly TIMEOUT cycles after START exit, with rsp_err=1 and rsp_product=0. The controller returns to IDLE after rsp_ready.
- Hold rsp0_ready=0 for 10 cycles with req1_valid=1: req1_ready stays 0 and rsp0 stays stable. Accepted 1 cycle after rsp0_ready.
- Assert Rst_n=0 during BUSY: all outputs 0 immediately (async). After release, state is IDLE and the next request starts a fresh job with a correct product.
